demux_stream_1ton: RTL and testbench
====================================

# demux_stream_1ton

Registered, parametrised 1-to-N stream demultiplexer. It routes each accepted input word to one output channel chosen by a select field, or to all channels in broadcast mode. Every channel has its own valid/ready handshake and a one-entry output register. It sits between a single producer and N independent consumers, and replaces combinational 1-to-4 demux use where backpressure is needed.

## Interface
- WIDTH, 8, data width in bits
- N, 4, number of output channels (2..16)
- SEL_W, $clog2(N), select width (derived; do not override)
- CNT_W, 8, width of the drop counter
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  producer has a word
- in_ready  out  1  block accepts the word this cycle
- in_data  in  WIDTH  input word
- in_sel  in  SEL_W  destination channel
- in_bcast  in  1  deliver to all N channels, ignoring in_sel
- out_valid  out  N  per-channel word available
- out_ready  in  N  per-channel consumer accepts
- out_data  out  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- drop_cnt  out  CNT_W  count of words dropped for an out-of-range select

## Operation
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Channel k is free when `!out_valid[k] || out_ready[k]`. A channel holding a word that drains this cycle may be reloaded in the same cycle.
- `in_ready` (combinational, no dependency on `in_valid`):
  - unicast, `in_sel < N`: channel `in_sel` is free;
  - unicast, `in_sel >= N` (possible only when N is not a power of 2): 1;
  - broadcast: all N channels free (all-or-nothing);
  - forced 0 while `rst` = 1.
- Accept = `in_valid && in_ready`. On accept:
  - unicast, valid select: load `in_data` into channel `in_sel` and set its `out_valid`;
  - unicast, out-of-range select: the word is discarded and `drop_cnt` increments, saturating at 2^CNT_W−1;
  - broadcast: load `in_data` into every channel and set every `out_valid`.
- Per channel, every cycle:
  - `out_ready[k] && out_valid[k]` clears `out_valid[k]` unless the channel is reloaded in the same cycle;
  - a reload takes priority and keeps `out_valid[k]` at 1 with the new data.
- `out_data[k]` changes only on load and holds while `out_valid[k]` = 1 and the channel is not consumed.
- Unused channels never glitch `out_valid`. A channel not selected keeps its state.
- No state machine beyond the per-channel full/empty bit and the drop counter.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `drop_cnt` = 0, `in_ready` = 0 during reset. In the first cycle after reset, `in_ready` = 1 for any select.
- Latency: a word accepted on edge t appears with `out_valid` = 1 after edge t. It can be consumed at edge t+1.
- Throughput: 1 word/cycle to a channel whose consumer holds `out_ready` = 1. Per-channel full throughput is sustained without bubbles.
- Blocked channel: `in_ready` = 0 only for selects pointing at a full, non-draining channel. A different `in_sel` in the same cycle is accepted (no head-of-line blocking inside the block).
- Reset mid-transfer: any words held in channels are lost. The producer must re-send.
- `in_bcast` = 1 with `in_sel` out of range: broadcast wins and nothing is dropped.

## Structure
- Shared header `demux_defs.vh` holds:
  - default WIDTH/N/CNT_W constants;
  - the `CHAN_SLICE(k)` part-select macro shared with the bench.
- Sub-module `demux_chan_reg` (WIDTH): a one-entry register slice with load, data_in, out_ready, out_valid, out_data and free.
- Top level:
  - instantiates N copies of `demux_chan_reg` with generate;
  - decodes `in_sel`/`in_bcast` into an N-bit load vector;
  - computes `in_ready`;
  - owns `drop_cnt`.

## Test plan
- Reset, then N=4, WIDTH=8, all `out_ready` = 1, send 0xA0..0xA3 with `in_sel` 0..3 on consecutive cycles -> each `out_valid[k]` pulses one cycle after its accept with `out_data[k]` = 0xA0+k, and `in_ready` stays 1.
- `out_ready[2]` = 0, send 0x11 then 0x22 to channel 2 -> 0x11 held, `in_ready` = 0 on the second word. 0x33 to channel 1 in that cycle is accepted. Raising `out_ready[2]` drains 0x11 and accepts 0x22 in the same cycle.
- Broadcast 0x5C with `out_ready[3]` = 0 and channel 3 full -> `in_ready` = 0 and no channel loads. After channel 3 drains, all four channels show 0x5C.
- N=5 (SEL_W=3), send 3 words with `in_sel` = 6 -> `in_ready` = 1, no `out_valid`, `drop_cnt` = 3. With CNT_W=2, 5 drops -> `drop_cnt` saturates at 3.
- Assert `rst` while channels 0 and 3 are full -> the next cycle shows `out_valid` = 0000, `out_data` = 0, `drop_cnt` = 0 and `in_ready` = 0 during `rst`.
- Random valid/ready/select stress, 10k cycles, N=4 -> a scoreboard sees per-channel in-order delivery with no loss or duplication.

Source files
------------

// File: rtl/demux_stream_1ton_pkg.sv
// Shared defaults and helpers for the 1-to-N stream demultiplexer slice.
// The channel part-select macro is also picked up by the bench.
`ifndef CHAN_SLICE
`define CHAN_SLICE(k) ((k)*WIDTH) +: WIDTH
`endif

package demux_stream_1ton_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N     = 4;
  localparam int DEF_CNT_W = 8;

  // Saturating increment used by the drop counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/demux_stream_1ton_chan_reg.sv
// One-entry output register for a single demux channel.
// Handshake: a word transfers on a rising edge where out_valid && out_ready.
module demux_chan_reg
  import demux_stream_1ton_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             free
);

  // A draining entry counts as free so a reload can land in the same cycle.
  assign free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= data_in;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer with unicast/broadcast routing,
// per-channel backpressure and a saturating counter of out-of-range drops.
module demux_stream_1ton
  import demux_stream_1ton_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int SEL_W = $clog2(N),
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_bcast,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]   drop_cnt
);

  logic [N-1:0] free;
  logic [N-1:0] sel_hit;
  logic [N-1:0] load;
  logic         sel_in_range;
  logic         accept;
  logic         drop;

  // Select range check only matters when N is not a power of two.
  assign sel_in_range = ({1'b0, in_sel} < (SEL_W+1)'(N));

  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < N; k++) begin
      sel_hit[k] = (in_sel == SEL_W'(k));
    end
  end

  // in_ready never looks at in_valid; broadcast is all-or-nothing.
  always_comb begin
    in_ready = 1'b0;
    if (rst) begin
      in_ready = 1'b0;
    end else if (in_bcast) begin
      in_ready = &free;
    end else if (sel_in_range) begin
      in_ready = |(sel_hit & free);
    end else begin
      in_ready = 1'b1;
    end
  end

  assign accept = in_valid && in_ready;
  assign drop   = accept && !in_bcast && !sel_in_range;

  always_comb begin
    load = '0;
    for (int k = 0; k < N; k++) begin
      load[k] = accept && (in_bcast || sel_hit[k]);
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_chan
    demux_chan_reg #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .data_in  (in_data),
      .out_ready(out_ready[k]),
      .out_valid(out_valid[k]),
      .out_data (out_data[`CHAN_SLICE(k)]),
      .free     (free[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop) begin
      drop_cnt <= CNT_W'(sat_inc(32'(drop_cnt), CNT_W));
    end
  end

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Bench for demux_stream_1ton: directed scenarios on N=4 and N=5/CNT_W=2
// instances, then a randomized run against a per-channel queue model.
`ifndef CHAN_SLICE
`define CHAN_SLICE(k) ((k)*WIDTH) +: WIDTH
`endif

module tb_demux_stream_1ton;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int N5    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data = '0;
  logic [1:0]         in_sel = '0;
  logic               in_bcast = 1'b0;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready = '0;
  logic [N*WIDTH-1:0] out_data;
  logic [7:0]         drop_cnt;

  logic                in5_valid = 1'b0;
  logic                in5_ready;
  logic [WIDTH-1:0]    in5_data = '0;
  logic [2:0]          in5_sel = '0;
  logic                in5_bcast = 1'b0;
  logic [N5-1:0]       out5_valid;
  logic [N5-1:0]       out5_ready = '0;
  logic [N5*WIDTH-1:0] out5_data;
  logic [1:0]          drop5_cnt;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] exp_q [N][$];

  always #5 clk = ~clk;

  demux_stream_1ton #(.WIDTH(WIDTH), .N(N), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt)
  );

  demux_stream_1ton #(.WIDTH(WIDTH), .N(N5), .CNT_W(2)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in5_valid), .in_ready(in5_ready),
    .in_data(in5_data), .in_sel(in5_sel), .in_bcast(in5_bcast),
    .out_valid(out5_valid), .out_ready(out5_ready), .out_data(out5_data),
    .drop_cnt(drop5_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (in5_ready !== 1'b0) begin bad++; $display("FAIL reset_in5_ready got=%b exp=0", in5_ready); end
    rst = 1'b0;
    for (int s = 0; s < N; s++) begin
      in_sel = 2'(s);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready sel=%0d got=%b exp=1", s, in_ready); end
    end
    in5_sel = 3'd6;
    #1;
    total++; if (in5_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready5 sel=6 got=%b exp=1", in5_ready); end
    tick();
  endtask

  task automatic test_unicast_seq();
    out_ready = 4'hF;
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_sel   = 2'(k);
      in_data  = 8'hA0 + 8'(k);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL seq_in_ready k=%0d got=%b exp=1", k, in_ready); end
      tick();
      total++; if (out_valid !== 4'(1 << k)) begin bad++; $display("FAIL seq_out_valid k=%0d got=%b exp=%b", k, out_valid, 4'(1 << k)); end
      total++; if (out_data[`CHAN_SLICE(k)] !== 8'hA0 + 8'(k)) begin bad++; $display("FAIL seq_out_data k=%0d got=%h exp=%h", k, out_data[`CHAN_SLICE(k)], 8'hA0 + 8'(k)); end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL seq_drain got=%b exp=0000", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1011;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h11;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_first_ready got=%b exp=1", in_ready); end
    tick();
    in_data = 8'h22;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_blocked_ready got=%b exp=0", in_ready); end
    in_sel = 2'd1; in_data = 8'h33;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_other_ready got=%b exp=1", in_ready); end
    tick();
    total++; if (out_valid !== 4'b0110) begin bad++; $display("FAIL bp_valid got=%b exp=0110", out_valid); end
    total++; if (out_data[`CHAN_SLICE(2)] !== 8'h11) begin bad++; $display("FAIL bp_hold2 got=%h exp=11", out_data[`CHAN_SLICE(2)]); end
    total++; if (out_data[`CHAN_SLICE(1)] !== 8'h33) begin bad++; $display("FAIL bp_ch1 got=%h exp=33", out_data[`CHAN_SLICE(1)]); end
    in_sel = 2'd2; in_data = 8'h22; out_ready = 4'b1111;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_drain_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 4'b0100) begin bad++; $display("FAIL bp_reload_valid got=%b exp=0100", out_valid); end
    total++; if (out_data[`CHAN_SLICE(2)] !== 8'h22) begin bad++; $display("FAIL bp_reload_data got=%h exp=22", out_data[`CHAN_SLICE(2)]); end
    tick();
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL bp_final got=%b exp=0000", out_valid); end
  endtask

  task automatic test_bcast_block();
    out_ready = 4'b0111;
    in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h77;
    tick();
    in_bcast = 1'b1; in_data = 8'h5C; in_sel = 2'd0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bc_blocked_ready got=%b exp=0", in_ready); end
    tick();
    total++; if (out_valid !== 4'b1000) begin bad++; $display("FAIL bc_noload_valid got=%b exp=1000", out_valid); end
    total++; if (out_data[`CHAN_SLICE(3)] !== 8'h77) begin bad++; $display("FAIL bc_noload_data got=%h exp=77", out_data[`CHAN_SLICE(3)]); end
    out_ready = 4'b1111;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bc_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'b0000;
    total++; if (out_valid !== 4'b1111) begin bad++; $display("FAIL bc_valid got=%b exp=1111", out_valid); end
    for (int k = 0; k < N; k++) begin
      total++; if (out_data[`CHAN_SLICE(k)] !== 8'h5C) begin bad++; $display("FAIL bc_data k=%0d got=%h exp=5c", k, out_data[`CHAN_SLICE(k)]); end
    end
    out_ready = 4'b1111;
    tick();
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL bc_drain got=%b exp=0000", out_valid); end
  endtask

  task automatic test_drop();
    out5_ready = 5'h1F;
    in5_valid = 1'b1; in5_bcast = 1'b1; in5_sel = 3'd6; in5_data = 8'h9E;
    #1;
    total++; if (in5_ready !== 1'b1) begin bad++; $display("FAIL drop_bc_ready got=%b exp=1", in5_ready); end
    tick();
    in5_bcast = 1'b0;
    total++; if (out5_valid !== 5'h1F) begin bad++; $display("FAIL drop_bc_valid got=%b exp=11111", out5_valid); end
    for (int k = 0; k < N5; k++) begin
      total++; if (out5_data[`CHAN_SLICE(k)] !== 8'h9E) begin bad++; $display("FAIL drop_bc_data k=%0d got=%h exp=9e", k, out5_data[`CHAN_SLICE(k)]); end
    end
    total++; if (drop5_cnt !== 2'd0) begin bad++; $display("FAIL drop_bc_cnt got=%0d exp=0", drop5_cnt); end
    for (int i = 0; i < 5; i++) begin
      in5_sel = (i < 3) ? 3'd6 : 3'd7;
      in5_data = 8'(i);
      #1;
      total++; if (in5_ready !== 1'b1) begin bad++; $display("FAIL drop_ready i=%0d got=%b exp=1", i, in5_ready); end
      tick();
      if (i == 2) begin
        total++; if (drop5_cnt !== 2'd3) begin bad++; $display("FAIL drop_cnt3 got=%0d exp=3", drop5_cnt); end
      end
      total++; if (out5_valid !== 5'h00) begin bad++; $display("FAIL drop_no_valid i=%0d got=%b exp=00000", i, out5_valid); end
    end
    in5_valid = 1'b0;
    total++; if (drop5_cnt !== 2'd3) begin bad++; $display("FAIL drop_sat got=%0d exp=3", drop5_cnt); end
  endtask

  task automatic test_reset_mid();
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hC0;
    tick();
    in_sel = 2'd3; in_data = 8'hC3;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 4'b1001) begin bad++; $display("FAIL rm_full got=%b exp=1001", out_valid); end
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rm_ready_in_rst got=%b exp=0", in_ready); end
    tick();
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL rm_valid got=%b exp=0000", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL rm_data got=%h exp=0", out_data); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL rm_drop got=%0d exp=0", drop_cnt); end
    total++; if (drop5_cnt !== 2'd0) begin bad++; $display("FAIL rm_drop5 got=%0d exp=0", drop5_cnt); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rm_ready got=%b exp=0", in_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random_stress();
    logic exp_ready;
    logic [N-1:0] tgt;
    for (int k = 0; k < N; k++) exp_q[k].delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel   = 2'($urandom_range(0, 3));
      in_bcast = ($urandom_range(0, 15) == 0);
      in_data  = 8'($urandom);
      for (int k = 0; k < N; k++) out_ready[k] = ($urandom_range(0, 3) != 0);
      #1;
      tgt = in_bcast ? 4'hF : 4'(1 << in_sel);
      exp_ready = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (tgt[k] && exp_q[k].size() != 0 && !out_ready[k]) exp_ready = 1'b0;
      end
      total++; if (in_ready !== exp_ready) begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready); end
      for (int k = 0; k < N; k++) begin
        total++; if (out_valid[k] !== (exp_q[k].size() != 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d ch=%0d got=%b exp=%b", cyc, k, out_valid[k], exp_q[k].size() != 0); end
        if (exp_q[k].size() != 0) begin
          total++; if (out_data[`CHAN_SLICE(k)] !== exp_q[k][0]) begin bad++; $display("FAIL rnd_data cyc=%0d ch=%0d got=%h exp=%h", cyc, k, out_data[`CHAN_SLICE(k)], exp_q[k][0]); end
        end
      end
      for (int k = 0; k < N; k++) begin
        if (exp_q[k].size() != 0 && out_ready[k]) void'(exp_q[k].pop_front());
        if (in_valid && exp_ready && tgt[k]) exp_q[k].push_back(in_data);
      end
      tick();
    end
    in_valid = 1'b0; in_bcast = 1'b0;
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL rnd_drop got=%0d exp=0", drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_unicast_seq();
    test_backpressure();
    test_bcast_block();
    test_drop();
    test_reset_mid();
    test_random_stress();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
